// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed seven-segment driver with frame-synchronous value updates.
// Optional PWM dimming when SEG_SCAN_BRIGHTNESS_EN is defined (adds bright_i).
module seg_scan #(
    parameter int unsigned DIGIT_PERIOD = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
`ifdef SEG_SCAN_BRIGHTNESS_EN
    input  logic [3:0]  bright_i,
`endif
    output logic [7:0]  pin_seg_o,
    output logic [3:0]  pin_seg_sel_o,
    output logic        frame_o
);

    localparam int unsigned CntW = $clog2(DIGIT_PERIOD);
    localparam logic [CntW-1:0] LastCnt   = CntW'(DIGIT_PERIOD - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } state_e;

    // A zero-length blank gap starts each slot directly in DRIVE.
    localparam state_e SlotStart = (BLANK_CYCLES == 0) ? StDrive : StBlank;

    typedef struct packed {
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [15:0] value;
    } disp_t;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      digit_q;
    disp_t           active_q;
    disp_t           pend_q;
    logic            pend_vld_q;
    logic [7:0]      seg_q;
    logic [3:0]      sel_q;
    logic            frame_q;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0]      pwm_q;
`endif

    disp_t      in_data;
    logic       boundary;
    logic       drive_on;
    logic [3:0] nibble;
    logic [7:0] seg_d;
    logic [3:0] sel_d;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] res;
        unique case (nib)
            4'h0: res = 7'h3F;
            4'h1: res = 7'h06;
            4'h2: res = 7'h5B;
            4'h3: res = 7'h4F;
            4'h4: res = 7'h66;
            4'h5: res = 7'h6D;
            4'h6: res = 7'h7D;
            4'h7: res = 7'h07;
            4'h8: res = 7'h7F;
            4'h9: res = 7'h6F;
            4'hA: res = 7'h77;
            4'hB: res = 7'h7C;
            4'hC: res = 7'h39;
            4'hD: res = 7'h5E;
            4'hE: res = 7'h79;
            4'hF: res = 7'h71;
            default: res = 7'h00;
        endcase
        return res;
    endfunction

    assign in_data  = '{blank: blank_i, dp: dp_i, value: value_i};
    assign boundary = (state_q == StDrive) && (digit_q == 2'd3) && (cnt_q == LastCnt);
    assign nibble   = active_q.value[{digit_q, 2'b00} +: 4];

    always_comb begin
        drive_on = (state_q == StDrive) && en_i && !active_q.blank[digit_q];
`ifdef SEG_SCAN_BRIGHTNESS_EN
        drive_on = drive_on && (pwm_q <= bright_i);
`endif
        seg_d = 8'h00;
        sel_d = 4'hF;
        if (drive_on) begin
            seg_d = {active_q.dp[digit_q], decode(nibble)};
            sel_d = ~(4'b0001 << digit_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            digit_q    <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= 8'h00;
            sel_q      <= 4'hF;
            frame_q    <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_q      <= '0;
`endif
        end else begin
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            frame_q <= boundary;

            // The display is dark while idle, so updates there cannot tear.
            if (state_q == StIdle) begin
                if (load_i) begin
                    active_q <= in_data;
                end else if (pend_vld_q) begin
                    active_q <= pend_q;
                end
                pend_vld_q <= 1'b0;
            end else if (boundary && (load_i || pend_vld_q)) begin
                active_q   <= load_i ? in_data : pend_q;
                pend_vld_q <= 1'b0;
            end else if (load_i) begin
                pend_q     <= in_data;
                pend_vld_q <= 1'b1;
            end

            if (!en_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                digit_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= SlotStart;
                        cnt_q   <= '0;
                        digit_q <= '0;
                    end
                    StBlank: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == BlankLast) begin
                            state_q <= StDrive;
                        end
                    end
                    StDrive: begin
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            digit_q <= digit_q + 2'd1;
                            state_q <= SlotStart;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        digit_q <= '0;
                    end
                endcase
            end

`ifdef SEG_SCAN_BRIGHTNESS_EN
            // Restart the PWM phase on every DRIVE entry, including back-to-back slots.
            if (en_i && (state_q == StDrive) && (cnt_q != LastCnt)) begin
                pwm_q <= pwm_q + 4'd1;
            end else begin
                pwm_q <= '0;
            end
`endif
        end
    end

    assign pin_seg_o     = seg_q;
    assign pin_seg_sel_o = sel_q;
    assign frame_o       = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed phases plus random loads checked against a
// slot-time model (position in frame computed arithmetically from cycles since enable).
module tb_seg_scan;

    localparam int unsigned P     = 8;
    localparam int unsigned B     = 2;
    localparam int unsigned FRAME = 4 * P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;
    logic [3:0]  blank = '0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0]  bright = 4'hF;
`endif
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame;

    seg_scan #(
        .DIGIT_PERIOD(P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .load_i       (load),
        .value_i      (value),
        .dp_i         (dp),
        .blank_i      (blank),
`ifdef SEG_SCAN_BRIGHTNESS_EN
        .bright_i     (bright),
`endif
        .pin_seg_o    (seg),
        .pin_seg_sel_o(sel),
        .frame_o      (frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: run = scanning, t = cycles since scan start; shown/pend hold {blank, dp, value}.
    logic [6:0]  font [16];
    bit          run;
    int unsigned t;
    logic [23:0] shown;
    logic [23:0] pend_data;
    bit          pend;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] inbus();
        return {blank, dp, value};
    endfunction

    function automatic void expect_out(output logic [7:0] es, output logic [3:0] esel);
        int unsigned c;
        int unsigned d;
        bit          lit;
        c    = t % P;
        d    = (t / P) % 4;
        es   = 8'h00;
        esel = 4'hF;
        lit  = run && en && (c >= B) && !shown[20 + d];
`ifdef SEG_SCAN_BRIGHTNESS_EN
        if (((c - B) % 16) > bright) lit = 1'b0;
`endif
        if (lit) begin
            es   = {shown[16 + d], font[shown[4 * d +: 4]]};
            esel = 4'hF ^ (4'b0001 << d);
        end
    endfunction

    task automatic tick();
        logic [7:0] es;
        logic [3:0] esel;
        bit         bnd;
        expect_out(es, esel);
        bnd = run && ((t % FRAME) == FRAME - 1);
        @(posedge clk);
        if (!run) begin
            if (load) shown = inbus();
            else if (pend) shown = pend_data;
            pend = 0;
        end else if (bnd && load) begin
            shown = inbus();
            pend  = 0;
        end else if (bnd && pend) begin
            shown = pend_data;
            pend  = 0;
        end else if (load) begin
            pend_data = inbus();
            pend      = 1;
        end
        if (!en) begin
            run = 0;
            t   = 0;
        end else if (!run) begin
            run = 1;
            t   = 0;
        end else begin
            t++;
        end
        #1;
        chk("seg", seg, es);
        chk("sel", {4'h0, sel}, {4'h0, esel});
        chk("frame", {7'h0, frame}, {7'h0, bnd});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the DUT is in frame position pos (before the next edge).
    task automatic wait_pos(input int unsigned pos);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            if (run && ((t % FRAME) == pos)) hit = 1;
            else tick();
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $error("FAIL wait_pos observed=timeout expected=pos%0d", pos);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dp    = d;
        blank = b;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = $urandom;
        dp    = $urandom;
        blank = $urandom;
    endtask

    task automatic model_reset();
        run       = 0;
        t         = 0;
        shown     = '0;
        pend_data = '0;
        pend      = 0;
    endtask

    initial begin
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_seg", seg, 8'h00);
        chk("rst_sel", {4'h0, sel}, 8'h0F);
        chk("rst_frame", {7'h0, frame}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable and show 1234
        en = 1'b1;
        do_load(16'h1234, 4'h0, 4'h0);
        ticks(3 * FRAME);

        // Two mid-frame loads: last one wins, applied at the boundary
        wait_pos(5);
        do_load(16'hABCD, 4'h0, 4'h0);
        ticks(6);
        do_load(16'hEF00, 4'h0, 4'h0);
        ticks(2 * FRAME);

        // Load exactly on the boundary cycle
        wait_pos(FRAME - 1);
        do_load(16'h8888, 4'h0, 4'h0);
        ticks(FRAME + 4);

        // Blank digit 3, decimal point on digit 0
        do_load(16'h5A3C, 4'b0001, 4'b1000);
        ticks(2 * FRAME + 3);

        // Disable mid-DRIVE on digit 2, then re-enable
        wait_pos(2 * P + 4);
        en = 1'b0;
        ticks(4);
        en = 1'b1;
        ticks(FRAME + 6);

        // Random loads and occasional disables
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 49) != 0);
            load  = ($urandom_range(0, 5) == 0);
            value = $urandom;
            dp    = $urandom;
            blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            if (i % 100 == 0) bright = $urandom;
`endif
            tick();
        end
        load = 1'b0;
        en   = 1'b1;
        do_load(16'h9876, 4'h0, 4'h0);
        ticks(FRAME);

        // Asynchronous reset mid-slot
        wait_pos(P + 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", seg, 8'h00);
        chk("arst_sel", {4'h0, sel}, 8'h0F);
        chk("arst_frame", {7'h0, frame}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_load(16'h0F1E, 4'b0101, 4'h0);
        ticks(2 * FRAME);

`ifdef SEG_SCAN_BRIGHTNESS_EN
        bright = 4'd3;
        ticks(2 * FRAME);
        bright = 4'd0;
        ticks(FRAME);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
